branch_resolve_unit: RTL and testbench

//  Parametrised successor to the combinational jump/branch select logic: resolves branch/jump ops in
//  the EX stage and drives the 2-bit next-PC select, link-write and flush. Adds a registered status

---
 rtl/bru_pkg.sv | 24 ++
 rtl/bru_bht.sv | 44 ++++
 rtl/branch_resolve_unit.sv | 139 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared codes for the branch resolve unit: resolve ops, next-PC selects, FSM states.
// BHT counters come out of reset weakly not-taken.
package bru_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_BEQ   = 3'd1;
  localparam logic [2:0] OP_BNEAL = 3'd2;
  localparam logic [2:0] OP_BALRN = 3'd3;
  localparam logic [2:0] OP_JRS   = 3'd4;
  localparam logic [2:0] OP_JMSUB = 3'd5;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_REL = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_REG = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] BHT_RST = 2'b01;

endpackage

// File: rtl/bru_bht.sv
// Branch history table: DEPTH 2-bit saturating counters, combinational read, one update per cycle.
// Read returns the pre-update value when read and update hit the same entry.
module bru_bht
  import bru_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];

  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) begin
      if (upd_taken && ctr_q[upd_idx] != 2'b11) begin
        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
      end else if (!upd_taken && ctr_q[upd_idx] != 2'b00) begin
        ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_RST;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: registered next-PC select, link write, flush and jump-wait stall.
// Optional BHT predictor is built only when BRU_BHT_EN is defined.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flag_we,
  input  logic [1:0]      status_in,
  input  logic            res_valid,
  input  logic [2:0]      res_op,
  input  logic [PC_W-1:0] res_pc,
  input  logic            res_pred_taken,
  input  logic            mem_rdy,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [1:0]      pc_sel,
  output logic            pc_sel_valid,
  output logic            link_we,
  output logic            mispredict,
  output logic            stall,
  output logic [1:0]      flags_q
);

  state_e     state_q, state_d;
  logic       jmsub_q, jmsub_d;
  logic [1:0] flags_d;
  logic [1:0] pc_sel_q, pc_sel_d;
  logic       pc_sel_valid_q, pc_sel_valid_d;
  logic       link_we_q, link_we_d;
  logic       mispredict_q, mispredict_d;
  logic       stall_q, stall_d;
  logic [1:0] eff_flags;
  logic       cond_op, cond_taken, pred_cmp, bht_upd;

  // Flags written this cycle are visible to the branch resolving in the same cycle.
  always_comb begin
    eff_flags  = flag_we ? status_in : flags_q;
    cond_op    = 1'b0;
    cond_taken = 1'b0;
    case (res_op)
      OP_BEQ:   begin cond_op = 1'b1; cond_taken = eff_flags[1];  end
      OP_BNEAL: begin cond_op = 1'b1; cond_taken = !eff_flags[1]; end
      OP_BALRN: begin cond_op = 1'b1; cond_taken = eff_flags[0];  end
      default:  ;
    endcase
  end

  always_comb begin
    flags_d        = flag_we ? status_in : flags_q;
    state_d        = state_q;
    jmsub_d        = jmsub_q;
    pc_sel_d       = SEL_SEQ;
    pc_sel_valid_d = 1'b0;
    link_we_d      = 1'b0;
    mispredict_d   = 1'b0;
    bht_upd        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (res_valid && cond_op) begin
          pc_sel_d       = !cond_taken ? SEL_SEQ : (res_op == OP_BALRN) ? SEL_REG : SEL_REL;
          pc_sel_valid_d = 1'b1;
          link_we_d      = cond_taken && (res_op != OP_BEQ);
          mispredict_d   = cond_taken != pred_cmp;
          bht_upd        = 1'b1;
        end else if (res_valid && (res_op == OP_JRS || res_op == OP_JMSUB)) begin
          state_d = ST_WAIT;
          jmsub_d = (res_op == OP_JMSUB);
        end
      end
      ST_WAIT: begin
        if (mem_rdy) begin
          pc_sel_d       = SEL_MEM;
          pc_sel_valid_d = 1'b1;
          link_we_d      = jmsub_q;
          mispredict_d   = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    stall_d = (state_d == ST_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      jmsub_q        <= 1'b0;
      flags_q        <= 2'b00;
      pc_sel_q       <= SEL_SEQ;
      pc_sel_valid_q <= 1'b0;
      link_we_q      <= 1'b0;
      mispredict_q   <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      jmsub_q        <= jmsub_d;
      flags_q        <= flags_d;
      pc_sel_q       <= pc_sel_d;
      pc_sel_valid_q <= pc_sel_valid_d;
      link_we_q      <= link_we_d;
      mispredict_q   <= mispredict_d;
      stall_q        <= stall_d;
    end
  end

  assign pc_sel       = pc_sel_q;
  assign pc_sel_valid = pc_sel_valid_q;
  assign link_we      = link_we_q;
  assign mispredict   = mispredict_q;
  assign stall        = stall_q;

  logic unused_pc;
  assign unused_pc = ^{fetch_pc, res_pc};

`ifdef BRU_BHT_EN
  bru_bht #(.DEPTH(BHT_DEPTH), .IDX_W(IDX_W)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (fetch_pc[IDX_W+1:2]),
    .rd_taken  (pred_taken),
    .upd_en    (bht_upd),
    .upd_idx   (res_pc[IDX_W+1:2]),
    .upd_taken (cond_taken)
  );
  assign pred_cmp = res_pred_taken;
`else
  // Without a predictor every taken conditional branch is a redirect.
  logic unused_nobht;
  assign unused_nobht = ^{res_pred_taken, bht_upd};
  assign pred_taken   = 1'b0;
  assign pred_cmp     = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized resolves
// checked against a behavioural model of flags, branch outcomes and predictor counters.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_we;
  logic [1:0]  status_in;
  logic        res_valid;
  logic [2:0]  res_op;
  logic [31:0] res_pc;
  logic        res_pred_taken;
  logic        mem_rdy;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [1:0]  pc_sel;
  logic        pc_sel_valid;
  logic        link_we;
  logic        mispredict;
  logic        stall;
  logic [1:0]  flags_q;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(32), .BHT_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .status_in(status_in),
    .res_valid(res_valid), .res_op(res_op), .res_pc(res_pc),
    .res_pred_taken(res_pred_taken), .mem_rdy(mem_rdy), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pc_sel(pc_sel), .pc_sel_valid(pc_sel_valid),
    .link_we(link_we), .mispredict(mispredict), .stall(stall), .flags_q(flags_q)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state
  int         m_ctr [16];
  logic [1:0] m_flags;
  logic [1:0] e_sel;
  logic       e_vld, e_link, e_misp;
  logic [7:0] obs, exp_v;

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic logic m_pred(logic [31:0] pc);
`ifdef BRU_BHT_EN
    return m_ctr[m_idx(pc)] >= 2;
`else
    return 1'b0;
`endif
  endfunction

  function void m_reset();
    m_flags = 2'b00;
    foreach (m_ctr[i]) m_ctr[i] = 1;
  endfunction

  // Computes the registered outcome of one cycle of IDLE-state activity.
  function void m_resolve(logic [2:0] op, logic pred, logic fwe, logic [1:0] st, logic [31:0] pc);
    logic [1:0] eff;
    logic       tk;
    eff    = fwe ? st : m_flags;
    e_sel  = 2'b00; e_vld = 1'b0; e_link = 1'b0; e_misp = 1'b0;
    if (op >= 3'd1 && op <= 3'd3) begin
      tk    = (op == 3'd1) ? eff[1] : (op == 3'd2) ? !eff[1] : eff[0];
      e_vld = 1'b1;
      e_sel = tk ? ((op == 3'd3) ? 2'b11 : 2'b01) : 2'b00;
      e_link = tk && (op != 3'd1);
`ifdef BRU_BHT_EN
      e_misp = (tk != pred);
`else
      e_misp = tk;
`endif
      if (tk) m_ctr[m_idx(pc)] = (m_ctr[m_idx(pc)] == 3) ? 3 : m_ctr[m_idx(pc)] + 1;
      else    m_ctr[m_idx(pc)] = (m_ctr[m_idx(pc)] == 0) ? 0 : m_ctr[m_idx(pc)] - 1;
    end
    if (fwe) m_flags = st;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic [2:0] op, logic pred, logic fwe, logic [1:0] st, logic [31:0] pc);
    res_valid = 1'b1; res_op = op; res_pred_taken = pred;
    flag_we = fwe; status_in = st; res_pc = pc;
  endtask

  task automatic idle_inputs();
    res_valid = 1'b0; res_op = 3'd0; flag_we = 1'b0; res_pred_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs(); status_in = 2'b00; mem_rdy = 1'b0; res_pc = '0; fetch_pc = '0;
    m_reset();
    repeat (2) @(negedge clk);
    obs = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
    if (obs !== 8'h00) $display("FAIL reset_outputs: got %b want %b", obs, 8'h00);
    else pass_cnt++;
    chk_cnt++;
    for (int i = 0; i < 4; i++) begin
      fetch_pc = $urandom;
      #1;
      if (pred_taken !== 1'b0) $display("FAIL reset_pred pc=%h: got %b want 0", fetch_pc, pred_taken);
      else pass_cnt++;
      chk_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    obs = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
    if (obs !== 8'h00) $display("FAIL reset_release: got %b want %b", obs, 8'h00);
    else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_flag_bypass();
    drive(3'd1, 1'b0, 1'b1, 2'b10, 32'h100);
    m_resolve(3'd1, 1'b0, 1'b1, 2'b10, 32'h100);
    cycle();
    idle_inputs();
    obs   = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
    exp_v = {e_sel, e_vld, e_link, e_misp, 1'b0, m_flags};
    if (obs !== exp_v) $display("FAIL flag_bypass_beq: got %b want %b", obs, exp_v);
    else pass_cnt++;
    chk_cnt++;
    cycle();
    obs   = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
    exp_v = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, m_flags};
    if (obs !== exp_v) $display("FAIL pulse_clears: got %b want %b", obs, exp_v);
    else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_balrn();
    logic [1:0] fl [2] = '{2'b01, 2'b00};
    for (int i = 0; i < 2; i++) begin
      flag_we = 1'b1; status_in = fl[i];
      m_resolve(3'd0, 1'b0, 1'b1, fl[i], 32'h0);
      cycle();
      flag_we = 1'b0;
      if (flags_q !== m_flags) $display("FAIL flag_write: got %b want %b", flags_q, m_flags);
      else pass_cnt++;
      chk_cnt++;
      drive(3'd3, 1'b1, 1'b0, 2'b11, 32'h200);
      m_resolve(3'd3, 1'b1, 1'b0, 2'b11, 32'h200);
      cycle();
      idle_inputs();
      obs   = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
      exp_v = {e_sel, e_vld, e_link, e_misp, 1'b0, m_flags};
      if (obs !== exp_v) $display("FAIL balrn flags=%b: got %b want %b", fl[i], obs, exp_v);
      else pass_cnt++;
      chk_cnt++;
    end
  endtask

  task automatic test_jump_wait();
    logic [2:0] ops [2] = '{3'd5, 3'd4};
    int         waits;
    for (int j = 0; j < 2; j++) begin
      waits = (j == 0) ? 3 : int'($urandom_range(0, 4));
      drive(ops[j], 1'b0, 1'b0, 2'b00, 32'h300);
      mem_rdy = 1'b1;
      cycle();
      idle_inputs(); mem_rdy = 1'b0;
      for (int k = 1; k <= waits + 1; k++) begin
        obs   = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
        exp_v = {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, m_flags};
        if (obs !== exp_v) $display("FAIL wait_stall op=%0d k=%0d: got %b want %b", ops[j], k, obs, exp_v);
        else pass_cnt++;
        chk_cnt++;
        res_valid = (k == 2); res_op = 3'd2;
        if (k == waits + 1) mem_rdy = 1'b1;
        cycle();
        idle_inputs();
      end
      mem_rdy = 1'b0;
      obs   = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
      exp_v = {2'b10, 1'b1, (ops[j] == 3'd5), 1'b1, 1'b0, m_flags};
      if (obs !== exp_v) $display("FAIL jump_pulse op=%0d: got %b want %b", ops[j], obs, exp_v);
      else pass_cnt++;
      chk_cnt++;
      cycle();
      obs   = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
      exp_v = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, m_flags};
      if (obs !== exp_v) $display("FAIL jump_after op=%0d: got %b want %b", ops[j], obs, exp_v);
      else pass_cnt++;
      chk_cnt++;
    end
  endtask

  task automatic test_reset_in_wait();
    drive(3'd5, 1'b0, 1'b0, 2'b00, 32'h300);
    cycle();
    idle_inputs();
    cycle();
    if (stall !== 1'b1) $display("FAIL rst_wait_stall: got %b want 1", stall);
    else pass_cnt++;
    chk_cnt++;
    rst_n = 1'b0;
    m_reset();
    #1;
    obs = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
    if (obs !== 8'h00) $display("FAIL rst_wait_async: got %b want %b", obs, 8'h00);
    else pass_cnt++;
    chk_cnt++;
    @(negedge clk);
    rst_n = 1'b1; mem_rdy = 1'b1;
    cycle();
    mem_rdy = 1'b0;
    obs = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
    if (obs !== 8'h00) $display("FAIL rst_wait_dropped: got %b want %b", obs, 8'h00);
    else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_bht();
    logic [1:0] sts [2] = '{2'b10, 2'b00};
    fetch_pc = 32'h40;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        drive(3'd1, m_pred(32'h40), 1'b1, sts[p], 32'h40);
        #1;
        if (pred_taken !== m_pred(32'h40)) $display("FAIL bht_pre p=%0d i=%0d: got %b want %b", p, i, pred_taken, m_pred(32'h40));
        else pass_cnt++;
        chk_cnt++;
        m_resolve(3'd1, res_pred_taken, 1'b1, sts[p], 32'h40);
        cycle();
        idle_inputs();
        obs   = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
        exp_v = {e_sel, e_vld, e_link, e_misp, 1'b0, m_flags};
        if (obs !== exp_v) $display("FAIL bht_resolve p=%0d i=%0d: got %b want %b", p, i, obs, exp_v);
        else pass_cnt++;
        chk_cnt++;
        if (pred_taken !== m_pred(32'h40)) $display("FAIL bht_post p=%0d i=%0d: got %b want %b", p, i, pred_taken, m_pred(32'h40));
        else pass_cnt++;
        chk_cnt++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(3'd1, 1'b0, 1'b1, 2'b10, 32'h40);
      m_resolve(3'd1, 1'b0, 1'b1, 2'b10, 32'h40);
      cycle();
      idle_inputs();
    end
    fetch_pc = 32'h80;
    #1;
    if (pred_taken !== m_pred(32'h80)) $display("FAIL bht_alias: got %b want %b", pred_taken, m_pred(32'h80));
    else pass_cnt++;
    chk_cnt++;
    fetch_pc = 32'h44;
    #1;
    if (pred_taken !== m_pred(32'h44)) $display("FAIL bht_neighbour: got %b want %b", pred_taken, m_pred(32'h44));
    else pass_cnt++;
    chk_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] op_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    logic [2:0]  op;
    logic [31:0] pc;
    for (int n = 0; n < 300; n++) begin
      op = op_tab[$urandom_range(0, 5)];
      pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      drive(op, 1'($urandom), 1'($urandom), 2'($urandom), pc);
      fetch_pc = ($urandom_range(0, 3) == 0) ? pc : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      #1;
      if (pred_taken !== m_pred(fetch_pc)) $display("FAIL rand_pred n=%0d pc=%h: got %b want %b", n, fetch_pc, pred_taken, m_pred(fetch_pc));
      else pass_cnt++;
      chk_cnt++;
      m_resolve(op, res_pred_taken, flag_we, status_in, pc);
      cycle();
      idle_inputs();
      obs   = {pc_sel, pc_sel_valid, link_we, mispredict, stall, flags_q};
      exp_v = {e_sel, e_vld, e_link, e_misp, 1'b0, m_flags};
      if (obs !== exp_v) $display("FAIL rand_resolve n=%0d op=%0d: got %b want %b", n, op, obs, exp_v);
      else pass_cnt++;
      chk_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_flag_bypass();
    test_balrn();
    test_jump_wait();
    test_reset_in_wait();
    test_bht();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
